// File: rtl/instr_queue_if.sv
// Fetch/dispatch bundle for the circular instruction queue.
// master = fetch/dispatch side, slave = the queue itself.
interface instr_queue_if #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IN_LANES + 1);
  localparam int OW = $clog2(OUT_LANES + 1);

  logic                          flush;
  logic [IN_LANES*WIDTH-1:0]     in_data;
  logic [IN_LANES-1:0]           in_valid;
  logic [OW-1:0]                 pop_count;
  logic [OUT_LANES*WIDTH-1:0]    out_data;
  logic [OUT_LANES-1:0]          out_valid;
  logic [IW-1:0]                 in_count;
  logic [CW-1:0]                 empty_count;
  logic [CW-1:0]                 count;

  modport master (
    output flush, in_data, in_valid, pop_count,
    input  out_data, out_valid, in_count, empty_count, count
  );

  modport slave (
    input  flush, in_data, in_valid, pop_count,
    output out_data, out_valid, in_count, empty_count, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular multi-lane instruction queue between fetch and dispatch; no data shifting.
// Optional overflow-stall performance counter enabled by defining IQ_PERF_CNT_EN.
module instr_queue #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int IN_LANES  = 4,
  parameter int OUT_LANES = 4
) (
  input  logic               clk,
  input  logic               reset,
  instr_queue_if.slave       bus
`ifdef IQ_PERF_CNT_EN
  ,
  output logic [31:0]        ovf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IN_LANES + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 1;

  logic [PW-1:0]              head, tail;
  logic [CW-1:0]              count;
  logic [WIDTH-1:0]           mem [DEPTH];

  logic [CW-1:0]              pop_req, pop_eff, free_slots;
  logic [IW-1:0]              push_req, push_eff, in_count;
  logic                       run;
  logic [OUT_LANES*WIDTH-1:0] out_data;
  logic [OUT_LANES-1:0]       out_valid;

  // Pointer advance with an explicit compare, so non-power-of-2 depths wrap correctly.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input logic [SW-1:0] off);
    logic [SW-1:0] sum;
    sum = SW'(base) + off;
    if (sum >= SW'(DEPTH)) sum = sum - SW'(DEPTH);
    return sum[PW-1:0];
  endfunction

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    pop_req = CW'(bus.pop_count);
    pop_eff = pop_req;
    if (count < pop_eff)              pop_eff = count;
    if (CW'(OUT_LANES) < pop_eff)     pop_eff = CW'(OUT_LANES);
  end

  // Only the contiguous run of valid lanes starting at lane 0 is offered.
  always_comb begin
    push_req = '0;
    run      = 1'b1;
    for (int i = 0; i < IN_LANES; i++) begin
      if (run && bus.in_valid[i]) push_req = push_req + IW'(1);
      else                        run      = 1'b0;
    end
  end

  always_comb begin
    free_slots = CW'(DEPTH) - count + pop_eff;
    in_count   = (free_slots < CW'(IN_LANES)) ? IW'(free_slots) : IW'(IN_LANES);
    push_eff   = (push_req < in_count) ? push_req : in_count;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= wrap_add(head, SW'(pop_eff));
      tail  <= wrap_add(tail, SW'(push_eff));
      count <= count + CW'(push_eff) - pop_eff;
    end
  end

  // NOTE: storage has no reset; head/tail/count alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (!bus.flush) begin
      for (int i = 0; i < IN_LANES; i++) begin
        if (IW'(i) < push_eff) mem[wrap_add(tail, SW'(i))] <= bus.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Outputs come only from registered state, so there is no in->out path.
  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      if (CW'(j) < count) begin
        out_valid[j]                = 1'b1;
        out_data[j*WIDTH +: WIDTH]  = mem[wrap_add(head, SW'(j))];
      end
    end
  end

  assign bus.out_data    = out_data;
  assign bus.out_valid   = out_valid;
  assign bus.in_count    = in_count;
  assign bus.count       = count;
  assign bus.empty_count = CW'(DEPTH) - count;

`ifdef IQ_PERF_CNT_EN
  // Saturating; survives flush so mispredict-heavy phases still show fetch back-pressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_stall_cnt <= '0;
    end else if (!bus.flush && (push_req > push_eff) && (ovf_stall_cnt != '1)) begin
      ovf_stall_cnt <= ovf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: DEPTH=8 and DEPTH=6 instances against a queue-based scoreboard.
module tb_instr_queue;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instr_queue_if #(.WIDTH(32), .DEPTH(8), .IN_LANES(4), .OUT_LANES(4)) bus_a ();
  instr_queue_if #(.WIDTH(32), .DEPTH(6), .IN_LANES(4), .OUT_LANES(4)) bus_b ();

`ifdef IQ_PERF_CNT_EN
  logic [31:0] ovf_a, ovf_b;
`endif

  instr_queue #(.WIDTH(32), .DEPTH(8), .IN_LANES(4), .OUT_LANES(4)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
`ifdef IQ_PERF_CNT_EN
    , .ovf_stall_cnt(ovf_a)
`endif
  );

  instr_queue #(.WIDTH(32), .DEPTH(6), .IN_LANES(4), .OUT_LANES(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
`ifdef IQ_PERF_CNT_EN
    , .ovf_stall_cnt(ovf_b)
`endif
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq_a [$];
  logic [31:0] mq_b [$];
  int          exp_ovf [2];
  logic [31:0] word_ctr = 32'h1000_0000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus_a.flush = 1'b0; bus_a.in_valid = '0; bus_a.pop_count = '0; bus_a.in_data = '0;
    bus_b.flush = 1'b0; bus_b.in_valid = '0; bus_b.pop_count = '0; bus_b.in_data = '0;
  endtask

  task automatic read_dut(input int d, output logic [127:0] od, output logic [3:0] ov,
                          output int oc, output int oe, output int oi);
    if (d == 0) begin
      od = bus_a.out_data; ov = bus_a.out_valid;
      oc = int'(bus_a.count); oe = int'(bus_a.empty_count); oi = int'(bus_a.in_count);
    end else begin
      od = bus_b.out_data; ov = bus_b.out_valid;
      oc = int'(bus_b.count); oe = int'(bus_b.empty_count); oi = int'(bus_b.in_count);
    end
  endtask

  // Compare every visible output against the scoreboard contents.
  task automatic verify(input int d);
    logic [127:0] od; logic [3:0] ov; logic [3:0] therm; logic [31:0] exp;
    int oc, oe, oi, dep, size;
    dep  = (d == 0) ? 8 : 6;
    size = (d == 0) ? mq_a.size() : mq_b.size();
    read_dut(d, od, ov, oc, oe, oi);
    therm = '0;
    for (int j = 0; j < 4; j++) if (j < size) therm[j] = 1'b1;
    check("count", oc, size);
    check("empty_count", oe, dep - size);
    check("out_valid", ov, therm);
    for (int j = 0; j < 4; j++) begin
      exp = '0;
      if (j < size) exp = (d == 0) ? mq_a[j] : mq_b[j];
      check($sformatf("out_data[%0d]", j), od[j*32 +: 32], exp);
    end
`ifdef IQ_PERF_CNT_EN
    check("ovf_stall_cnt", (d == 0) ? ovf_a : ovf_b, exp_ovf[d]);
`endif
  endtask

  // One clock cycle on instance d: drive, predict, check combinational and popped data, then state.
  task automatic cyc(input int d, input logic [3:0] v, input int pop, input logic fl);
    logic [127:0] data, od; logic [3:0] ov; logic [31:0] exp;
    int oc, oe, oi, dep, size, pe, req, ic, push;
    dep  = (d == 0) ? 8 : 6;
    size = (d == 0) ? mq_a.size() : mq_b.size();
    for (int i = 0; i < 4; i++) begin
      data[i*32 +: 32] = word_ctr;
      word_ctr++;
    end
    idle();
    if (d == 0) begin
      bus_a.flush = fl; bus_a.in_valid = v; bus_a.pop_count = 3'(pop); bus_a.in_data = data;
    end else begin
      bus_b.flush = fl; bus_b.in_valid = v; bus_b.pop_count = 3'(pop); bus_b.in_data = data;
    end
    pe = pop;
    if (pe > size) pe = size;
    if (pe > 4)    pe = 4;
    req = 0;
    while (req < 4 && v[req]) req++;
    ic = dep - size + pe;
    if (ic > 4) ic = 4;
    push = (req < ic) ? req : ic;

    @(negedge clk);
    read_dut(d, od, ov, oc, oe, oi);
    check("in_count", oi, ic);
    if (fl) begin
      if (d == 0) mq_a.delete(); else mq_b.delete();
    end else begin
      for (int j = 0; j < pe; j++) begin
        exp = (d == 0) ? mq_a.pop_front() : mq_b.pop_front();
        check($sformatf("popped[%0d]", j), od[j*32 +: 32], exp);
      end
      for (int i = 0; i < push; i++) begin
        if (d == 0) mq_a.push_back(data[i*32 +: 32]); else mq_b.push_back(data[i*32 +: 32]);
      end
      if (req > push) exp_ovf[d]++;
    end
    @(posedge clk);
    #1;
    verify(d);
  endtask

  initial begin
    logic [127:0] od; logic [3:0] ov; int oc, oe, oi;
    exp_ovf[0] = 0;
    exp_ovf[1] = 0;
    idle();

    // Reset defaults
    #12;
    read_dut(0, od, ov, oc, oe, oi);
    check("rst_in_count_a", oi, 4);
    verify(0);
    read_dut(1, od, ov, oc, oe, oi);
    check("rst_in_count_b", oi, 4);
    verify(1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Basic push of four lanes, then fill and stall while full
    cyc(0, 4'b1111, 0, 1'b0);
    cyc(0, 4'b1111, 0, 1'b0);
    cyc(0, 4'b1111, 0, 1'b0);
    cyc(0, 4'b1111, 0, 1'b0);

    // Full with a same-cycle pop of 3: only 3 lanes accepted
    cyc(0, 4'b1111, 3, 1'b0);

    // Non-contiguous valid, then over-sized pop
    cyc(0, 4'b0000, 0, 1'b1);
    cyc(0, 4'b1011, 0, 1'b0);
    cyc(0, 4'b0000, 4, 1'b0);
    cyc(0, 4'b1111, 0, 1'b0);

    // Flush with count 5 while pushing and popping
    cyc(0, 4'b0001, 0, 1'b0);
    cyc(0, 4'b1111, 2, 1'b1);
    cyc(0, 4'b0111, 1, 1'b0);

    // Wrap on the non-power-of-2 instance
    for (int k = 0; k < 4; k++) begin
      cyc(1, 4'b1111, 0, 1'b0);
      cyc(1, 4'b0000, 3, 1'b0);
      cyc(1, 4'b1111, 0, 1'b0);
      cyc(1, 4'b0000, 4, 1'b0);
    end
    for (int k = 0; k < 24; k++) begin
      cyc(1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset mid-cycle clears outputs before the next edge
    cyc(0, 4'b1111, 0, 1'b0);
    idle();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    read_dut(0, od, ov, oc, oe, oi);
    check("async_count", oc, 0);
    check("async_out_valid", ov, 4'b0000);
    check("async_out_data", od[63:0], 64'h0);
    check("async_empty", oe, 8);
    mq_a.delete();
    mq_b.delete();
    exp_ovf[0] = 0;
    exp_ovf[1] = 0;
    verify(0);
    verify(1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 4'b0011, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
